// File: rtl/aes_spi_frontend.sv
// SPI slave front-end for the AES core: oversampled SPI pins, 256-bit {plaintext,key}
// frame deserialiser with length checking, and cyphertext serialiser.

module aes_spi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) sync_q <= '0;
        else           sync_q <= (sync_q << 1) | STAGES'(d_i);
    end

    assign q_o = sync_q[STAGES-1];
endmodule

module aes_spi_frontend #(
    parameter int BLK_W       = 128,
    parameter int KEY_W       = 128,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             sck_i,
    input  logic             sdi_i,
    input  logic             load_i,
    output logic             sdo_o,
    output logic             done_o,
    output logic             frame_err_o,
    output logic [KEY_W-1:0] key_o,
    output logic [BLK_W-1:0] plaintext_o,
    output logic             start_o,
    input  logic             core_done_i,
    input  logic [BLK_W-1:0] cyphertext_i
);
    localparam int FRAME_W = BLK_W + KEY_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FRAME_W);

    typedef enum logic [1:0] {IDLE, SHIFT_IN, WAIT_CORE, READY} state_e;

    // pin order: {load, sdi, sck}
    logic [2:0] pin_raw, pin_s;
    assign pin_raw = {load_i, sdi_i, sck_i};

    for (genvar g = 0; g < 3; g++) begin : g_sync
        aes_spi_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk_i    (clk_i),
            .reset_ni (reset_ni),
            .d_i      (pin_raw[g]),
            .q_o      (pin_s[g])
        );
    end

    logic sck_s, sdi_s, load_s;
    assign {load_s, sdi_s, sck_s} = pin_s;

    logic sck_prev_q, load_prev_q;
    logic sck_rise, sck_fall, load_rise, load_fall;
    assign sck_rise  =  sck_s  & ~sck_prev_q;
    assign sck_fall  = ~sck_s  &  sck_prev_q;
    assign load_rise =  load_s & ~load_prev_q;
    assign load_fall = ~load_s &  load_prev_q;

    state_e             state_q, state_d;
    logic [FRAME_W-1:0] in_sr_q, in_sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BLK_W-1:0]   out_sr_q, out_sr_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [BLK_W-1:0]   pt_q, pt_d;
    logic               done_q, done_d;
    logic               start_q, start_d;
    logic               frame_err_q, frame_err_d;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            sck_prev_q  <= 1'b0;
            load_prev_q <= 1'b0;
            in_sr_q     <= '0;
            cnt_q       <= '0;
            out_sr_q    <= '0;
            key_q       <= '0;
            pt_q        <= '0;
            done_q      <= 1'b0;
            start_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sck_prev_q  <= sck_s;
            load_prev_q <= load_s;
            in_sr_q     <= in_sr_d;
            cnt_q       <= cnt_d;
            out_sr_q    <= out_sr_d;
            key_q       <= key_d;
            pt_q        <= pt_d;
            done_q      <= done_d;
            start_q     <= start_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        in_sr_d     = in_sr_q;
        cnt_d       = cnt_q;
        out_sr_d    = out_sr_q;
        key_d       = key_q;
        pt_d        = pt_q;
        done_d      = done_q;
        start_d     = 1'b0;
        frame_err_d = frame_err_q;

        unique case (state_q)
            IDLE: begin
                if (load_rise) begin
                    state_d     = SHIFT_IN;
                    cnt_d       = '0;
                    frame_err_d = 1'b0;
                    done_d      = 1'b0;
                end
            end
            SHIFT_IN: begin
                // Bit acceptance is evaluated first so a bit landing with load fall still counts.
                if (sck_rise) begin
                    if (cnt_q == FULL) begin
                        frame_err_d = 1'b1;
                    end else begin
                        in_sr_d = {in_sr_q[FRAME_W-2:0], sdi_s};
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                if (load_fall) begin
                    if (cnt_d == FULL && !frame_err_d) begin
                        pt_d    = in_sr_d[FRAME_W-1:KEY_W];
                        key_d   = in_sr_d[KEY_W-1:0];
                        start_d = 1'b1;
                        state_d = WAIT_CORE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            WAIT_CORE: begin
                if (load_rise) begin
                    state_d     = SHIFT_IN;
                    cnt_d       = '0;
                    frame_err_d = 1'b0;
                    done_d      = 1'b0;
                end else if (core_done_i) begin
                    out_sr_d = cyphertext_i;
                    done_d   = 1'b1;
                    state_d  = READY;
                end
            end
            READY: begin
                if (load_rise) begin
                    state_d     = SHIFT_IN;
                    cnt_d       = '0;
                    frame_err_d = 1'b0;
                    done_d      = 1'b0;
                end else if (sck_fall) begin
                    out_sr_d = {out_sr_q[BLK_W-2:0], 1'b0};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sdo_o       = out_sr_q[BLK_W-1];
    assign done_o      = done_q;
    assign frame_err_o = frame_err_q;
    assign key_o       = key_q;
    assign plaintext_o = pt_q;
    assign start_o     = start_q;
endmodule
